picomips_param: RTL
===================

# picomips_param

Parametrised multi-cycle picoMips core: the next-generation processor top for the board. It generalises the 8-bit datapath to `DW` bits, the register file to `NREG` entries and the program space to `2**PCW` words. It adds a subtract operation, saturating fractional multiply, conditional and unconditional branches, and explicit two-phase switch handshake instructions with a stall indicator. Program memory is external and synchronous; the core drives its address and consumes its data.

## Interface
Parameters:
- `DW`, 8, data/accumulator width in bits (≥4)
- `NREG`, 4, number of general registers; power of two, ≥2; `RW = $clog2(NREG)`
- `PCW`, 5, program counter width; program depth `2**PCW`, and `PCW ≤ DW`
- Derived: `IW = 4 + RW + DW`, the instruction width

Ports:
- `Clock`  in  1  system clock, rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `SW`  in  DW  switch data operand
- `Handshake`  in  1  switch handshake; treated as already synchronised
- `ProgAddr`  out  PCW  program memory address; equals `pc`
- `ProgData`  in  IW  instruction word; valid one cycle after `ProgAddr` (synchronous ROM)
- `LED`  out  DW  accumulator value
- `Stalled`  out  1  high while waiting on `Handshake`

## Operation
- Instruction fields: `op = ProgData[IW-1:IW-4]`, `r = ProgData[DW+RW-1:DW]`, `imm = ProgData[DW-1:0]` (signed).
- Opcodes, with `acc` as the accumulator and `R` as the register file:
  - 0 NOP
  - 1 LDI: `acc = imm`
  - 2 LDR: `acc = R[r]`
  - 3 STR: `R[r] = acc`
  - 4 ADDI: `acc += imm`
  - 5 ADDR: `acc += R[r]`
  - 6 MULI: `acc = fmul(acc, imm)`
  - 7 MULR: `acc = fmul(acc, R[r])`
  - 8 INSW: wait until `Handshake == 1`, then `acc = SW`
  - 9 WREL: wait until `Handshake == 0`
  - 10 BRZ: if `acc == 0`, `pc = imm[PCW-1:0]`
  - 11 JMP: `pc = imm[PCW-1:0]`
  - 12 SUBR: `acc -= R[r]`
  - 13–15 execute as NOP
- Add and subtract: two's complement, wrap modulo `2**DW`, no flags.
- `fmul(a, b)`: signed full product `p[2DW-1:0]`; result is `p[2DW-2:DW-1]` (Q1.(DW-1) fractional multiply).
  - Special case: `a == b == -2**(DW-1)` saturates to `2**(DW-1) - 1`.
- State machine, two states:
  - FETCH: `ProgAddr = pc`; the ROM samples it on the next edge. Always goes to EXEC.
  - EXEC: decode `ProgData` and execute. Registers, `acc` and `pc` update on the edge leaving EXEC.
    - Non-branch instructions: `pc = pc + 1`, wrapping mod `2**PCW`.
    - INSW/WREL with the condition false: stay in EXEC, `pc`/`acc` unchanged, `Stalled = 1`.
    - Otherwise go to FETCH.
- `R` is a flop array: one write port, with read-during-write returning the old value. Only STR writes it. Register contents are not directly observable; verify through LDR.
- `LED = acc` combinationally from the register.
- `Stalled` is a registered output: it asserts on the edge entering a blocked EXEC and clears on the edge where the wait condition is met.

## Timing
- Reset (async assert, synchronous-release assumed at board level) sets:
  - `pc = 0`, `acc = 0`, `R[*] = 0`, state = FETCH
  - `Stalled = 0`, `LED = 0`, `ProgAddr = 0`
- The first instruction executes in the second cycle after `Reset` falls.
- Latency: 2 cycles per instruction. INSW/WREL take 2 + N cycles, where N is the number of EXEC cycles with the condition false.
- INSW samples `SW` on the same edge at which `Handshake == 1` is seen.
- `Handshake` already high on INSW entry: completes in 2 cycles with no stall; `Stalled` never asserts.
- Branch to the current address is legal and loops forever.
- BRZ not taken: `pc + 1`.
- `pc` at `2**PCW - 1`, non-branch: wraps to 0.
- STR then LDR of the same register on consecutive instructions returns the new value (the write completes before the next EXEC).
- Reset during a stall: `Stalled` clears immediately (async) and the core restarts at `pc = 0`.
- `Handshake` toggling during FETCH is ignored; it is only sampled in EXEC.

## Test plan
- DW=8: LDI 100, ADDI 100 → `LED = -56` (0xC8) after 4 cycles. SUBR with `R0 = 0xC8` from `acc = 0` → `LED = 0x38`.
- DW=8: LDI 64, MULI 64 → `LED = 32`. LDI −128, MULI −128 → `LED = 127` (saturation). LDI −128, MULI 127 → `LED = −127`.
- INSW with `Handshake = 0`, `SW = 0x5A`, then raise `Handshake` 5 cycles later:
  - `Stalled = 1` for those cycles; `LED = 0x5A` on the edge after `Handshake` rises.
  - Following WREL stalls until `Handshake = 0`.
- BRZ with `acc = 0` to 7 → next `ProgAddr = 7`. BRZ with `acc = 1` → `ProgAddr = pc + 1`. JMP from `pc = 31` (PCW=5) to 3 → `ProgAddr = 3`. NOP at 31 → `ProgAddr = 0`.
- NREG=8, DW=12: STR to R7 of 0x7FF, LDI 0, LDR R7 → `LED = 0x7FF`. All other registers read 0 after reset.
- Assert `Reset` mid-stall on INSW → `Stalled`, `LED` and `ProgAddr` go to 0 without a clock edge. After release, fetch restarts at 0.

Source files
------------

// File: rtl/picomips_param.sv
// rtl/picomips_param.sv - parametrised two-state multi-cycle picoMips core
// Accumulator machine with external synchronous program ROM and switch handshake stalls.
module picomips_param #(
   parameter int DW   = 8,
   parameter int NREG = 4,
   parameter int PCW  = 5,
   localparam int RW  = $clog2(NREG),
   localparam int IW  = 4 + RW + DW
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [DW-1:0]  SW,
   input  logic           Handshake,
   output logic [PCW-1:0] ProgAddr,
   input  logic [IW-1:0]  ProgData,
   output logic [DW-1:0]  LED,
   output logic           Stalled
);

   typedef enum logic {S_FETCH, S_EXEC} state_t;

   localparam logic [3:0] OP_LDI  = 4'd1;
   localparam logic [3:0] OP_LDR  = 4'd2;
   localparam logic [3:0] OP_STR  = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4;
   localparam logic [3:0] OP_ADDR = 4'd5;
   localparam logic [3:0] OP_MULI = 4'd6;
   localparam logic [3:0] OP_MULR = 4'd7;
   localparam logic [3:0] OP_INSW = 4'd8;
   localparam logic [3:0] OP_WREL = 4'd9;
   localparam logic [3:0] OP_BRZ  = 4'd10;
   localparam logic [3:0] OP_JMP  = 4'd11;
   localparam logic [3:0] OP_SUBR = 4'd12;

   localparam logic [DW-1:0]  MIN_VAL = {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0]  MAX_VAL = {1'b0, {(DW-1){1'b1}}};
   localparam logic [PCW-1:0] PC_ONE  = {{(PCW-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [PCW-1:0]   pc_q, pc_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic             stalled_q, stalled_d;
   logic [DW-1:0]    regs_q [NREG];
   logic             reg_we;

   logic [3:0]       op;
   logic [RW-1:0]    rsel;
   logic [DW-1:0]    imm;
   logic [DW-1:0]    rval;

   assign op   = ProgData[IW-1 -: 4];
   assign rsel = ProgData[DW +: RW];
   assign imm  = ProgData[DW-1:0];
   assign rval = regs_q[rsel];

   // Q1.(DW-1) multiply; only (-1)*(-1) overflows the fractional range, so clamp it.
   function automatic logic [DW-1:0] fmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [2*DW-1:0] ax, bx, p;
      ax = {{DW{a[DW-1]}}, a};
      bx = {{DW{b[DW-1]}}, b};
      p  = ax * bx;
      if (a == MIN_VAL && b == MIN_VAL) begin
         return MAX_VAL;
      end
      return p[2*DW-2:DW-1];
   endfunction

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      stalled_d = 1'b0;
      reg_we    = 1'b0;
      case (state_q)
         S_FETCH: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_FETCH;
            pc_d    = pc_q + PC_ONE;
            case (op)
               OP_LDI:  acc_d = imm;
               OP_LDR:  acc_d = rval;
               OP_STR:  reg_we = 1'b1;
               OP_ADDI: acc_d = acc_q + imm;
               OP_ADDR: acc_d = acc_q + rval;
               OP_MULI: acc_d = fmul(acc_q, imm);
               OP_MULR: acc_d = fmul(acc_q, rval);
               OP_INSW: begin
                  if (Handshake) begin
                     acc_d = SW;
                  end else begin
                     state_d   = S_EXEC;
                     pc_d      = pc_q;
                     stalled_d = 1'b1;
                  end
               end
               OP_WREL: begin
                  if (Handshake) begin
                     state_d   = S_EXEC;
                     pc_d      = pc_q;
                     stalled_d = 1'b1;
                  end
               end
               OP_BRZ: begin
                  if (acc_q == '0) begin
                     pc_d = imm[PCW-1:0];
                  end
               end
               OP_JMP:  pc_d = imm[PCW-1:0];
               OP_SUBR: acc_d = acc_q - rval;
               default: ;
            endcase
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_FETCH;
         pc_q      <= '0;
         acc_q     <= '0;
         stalled_q <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         stalled_q <= stalled_d;
         if (reg_we) begin
            regs_q[rsel] <= acc_q;
         end
      end
   end

   assign ProgAddr = pc_q;
   assign LED      = acc_q;
   assign Stalled  = stalled_q;

endmodule
